// File: rtl/keying_pkg.sv
// Shared definitions for the keying modulator: mode codes, FSM states,
// and the per-mode keying function.
package keying_pkg;

    localparam logic [1:0] MODE_OOK = 2'b00;
    localparam logic [1:0] MODE_FSK = 2'b01;
    localparam logic [1:0] MODE_PSK = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_TX
    } state_t;

    function automatic logic key_bit(
        input logic [1:0] m,
        input logic       b,
        input logic       ca,
        input logic       cb
    );
        logic r;
        r = 1'b0;
        case (m)
            MODE_OOK: r = ca & b;
            MODE_FSK: r = b ? cb : ca;
            MODE_PSK: r = b ? ca : ~ca;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/keying_tone_div.sv
// Free-running square-wave carrier: toggles every `half` clocks.
// A half value of 0 behaves as 1.
module keying_tone_div #(
    parameter int DIV_W = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] half,
    output logic             car
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;

    assign last = (half == '0) ? '0 : half - DIV_W'(1);

    // >= lets the counter recover at once when half shrinks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            car <= 1'b0;
        end else if (cnt >= last) begin
            cnt <= '0;
            car <= ~car;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/keying_modem.sv
// OOK/BFSK/BPSK keying modulator with valid/ready word input.
// Define KEYING_DEMOD_EN to build the OOK envelope demodulator.
module keying_modem
    import keying_pkg::*;
#(
    parameter int MSG_W       = 8,
    parameter int DIV_W       = 27,
    parameter int DEMOD_SLACK = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] car_half,
    input  logic [DIV_W-1:0] car2_half,
    input  logic [DIV_W-1:0] bit_len,
    input  logic [MSG_W-1:0] msg_data,
    input  logic             msg_valid,
    output logic             msg_ready,
    output logic             tx_active,
    output logic             bit_out,
    output logic             mod_out,
    output logic             word_done,
    output logic             demod_out
);

    localparam int IDX_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;

    state_t           state;
    logic [MSG_W-1:0] shreg;
    logic [IDX_W-1:0] bit_idx;
    logic [DIV_W-1:0] bit_ctr;
    logic [DIV_W-1:0] ca_q;
    logic [DIV_W-1:0] cb_q;
    logic [DIV_W-1:0] bl_q;
    logic [1:0]       mode_q;
    logic             car_a;
    logic             car_b;
    logic [DIV_W-1:0] last_ctr;
    logic             last_bit;
    logic             end_word;
    logic             xfer;

    keying_tone_div #(.DIV_W(DIV_W)) u_car_a (
        .clk   (clk),
        .rst_n (rst_n),
        .half  (ca_q),
        .car   (car_a)
    );

    keying_tone_div #(.DIV_W(DIV_W)) u_car_b (
        .clk   (clk),
        .rst_n (rst_n),
        .half  (cb_q),
        .car   (car_b)
    );

    assign last_ctr  = (bl_q == '0) ? '0 : bl_q - DIV_W'(1);
    assign last_bit  = (bit_idx == IDX_W'(MSG_W - 1));
    assign end_word  = (state == ST_TX) && last_bit && (bit_ctr == last_ctr);
    assign msg_ready = (state == ST_IDLE) || end_word;
    assign xfer      = msg_valid && msg_ready;
    assign tx_active = (state == ST_TX);
    assign bit_out   = tx_active & shreg[MSG_W-1];

    // A transfer in the last cycle of a word reloads with no idle gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_idx   <= '0;
            bit_ctr   <= '0;
            ca_q      <= '0;
            cb_q      <= '0;
            bl_q      <= '0;
            mode_q    <= MODE_OOK;
            word_done <= 1'b0;
            mod_out   <= 1'b0;
        end else begin
            word_done <= end_word;
            mod_out   <= tx_active ? key_bit(mode_q, bit_out, car_a, car_b) : 1'b0;
            if (xfer) begin
                state   <= ST_TX;
                shreg   <= msg_data;
                bit_idx <= '0;
                bit_ctr <= '0;
                mode_q  <= mode;
                ca_q    <= car_half;
                cb_q    <= car2_half;
                bl_q    <= bit_len;
            end else if (state == ST_TX) begin
                if (bit_ctr == last_ctr) begin
                    bit_ctr <= '0;
                    if (last_bit) begin
                        state <= ST_IDLE;
                    end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                        shreg   <= shreg << 1;
                    end
                end else begin
                    bit_ctr <= bit_ctr + DIV_W'(1);
                end
            end
        end
    end

`ifdef KEYING_DEMOD_EN
    logic [DIV_W-1:0] low_cnt;
    logic [DIV_W:0]   low_lim;

    assign low_lim = {1'b0, ca_q} + (DIV_W+1)'(DEMOD_SLACK);

    // Envelope detector: a long enough low run means the carrier is off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt   <= '0;
            demod_out <= 1'b0;
        end else begin
            if (mod_out) begin
                low_cnt <= '0;
            end else if (low_cnt != '1) begin
                low_cnt <= low_cnt + DIV_W'(1);
            end
            demod_out <= tx_active && (mode_q == MODE_OOK) &&
                         ({1'b0, low_cnt} <= low_lim);
        end
    end
`else
    assign demod_out = 1'b0;
`endif

endmodule
